// File: rtl/polar_pkg.sv
// Shared state encoding, Q1.16 sine table and coefficient helpers
// for the sequential polar-to-cartesian converter.
package polar_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned SIN_N = 19;

    // round(sin(k*5 deg) * 2^16), k = 0..18
    localparam logic [16:0] SIN_Q16 [SIN_N] = '{
        17'd0,     17'd5712,  17'd11380, 17'd16962,
        17'd22415, 17'd27697, 17'd32768, 17'd37590,
        17'd42126, 17'd46341, 17'd50203, 17'd53684,
        17'd56756, 17'd59396, 17'd61584, 17'd63303,
        17'd64540, 17'd65287, 17'd65536
    };

    function automatic int n_angles(input int step_deg);
        return 360 / step_deg;
    endfunction

    // S(idx*5 deg) rounded half up to fb fractional bits
    function automatic logic [16:0] sin_coef(
        input int unsigned idx,
        input int unsigned fb
    );
        logic [17:0] t;
        if (idx >= SIN_N) return '0;
        if (fb >= 16) return SIN_Q16[idx[4:0]];
        t = {1'b0, SIN_Q16[idx[4:0]]} + (18'd1 << (15 - fb));
        return 17'(t >> (16 - fb));
    endfunction

endpackage

// File: rtl/trig_coef_lookup.sv
// Maps an angle index to |sin|, |cos| coefficients and quadrant signs.
// Out-of-range indices yield zero coefficients and err_o.
module trig_coef_lookup
    import polar_pkg::*;
#(
    parameter int FRAC_BITS      = 8,
    parameter int ANGLE_STEP_DEG = 15,
    parameter int ANGLE_W        = 5
) (
    input  logic [ANGLE_W-1:0] angle_idx_i,
    output logic [FRAC_BITS:0] sin_mag_o,
    output logic [FRAC_BITS:0] cos_mag_o,
    output logic               sign_x_o,
    output logic               sign_y_o,
    output logic               err_o
);

    localparam int unsigned N_ANG  = n_angles(ANGLE_STEP_DEG);
    localparam int unsigned K_STEP = ANGLE_STEP_DEG / 5;
    localparam int unsigned CW     = FRAC_BITS + 1;

    // k is the angle in 5-degree units; 18 units per quadrant
    int unsigned k;
    int unsigned rho;
    logic        quad_odd;

    always_comb begin
        k         = 32'(angle_idx_i) * K_STEP;
        rho       = k % 32'd18;
        quad_odd  = ((k / 32'd18) % 32'd2) == 32'd1;
        err_o     = 32'(angle_idx_i) >= N_ANG;
        sin_mag_o = '0;
        cos_mag_o = '0;
        sign_x_o  = 1'b0;
        sign_y_o  = 1'b0;
        if (!err_o) begin
            if (quad_odd) begin
                sin_mag_o = CW'(sin_coef(32'd18 - rho, FRAC_BITS));
                cos_mag_o = CW'(sin_coef(rho, FRAC_BITS));
            end else begin
                sin_mag_o = CW'(sin_coef(rho, FRAC_BITS));
                cos_mag_o = CW'(sin_coef(32'd18 - rho, FRAC_BITS));
            end
            sign_x_o = (k > 32'd18) && (k < 32'd54);
            sign_y_o = k > 32'd36;
        end
    end

endmodule

// File: rtl/polar_to_cart_seq.sv
// Bit-serial polar-to-cartesian converter: x = r*cos, y = r*sin,
// one coefficient bit per cycle, valid/ready on both sides.
module polar_to_cart_seq
    import polar_pkg::*;
#(
    parameter int R_WIDTH        = 8,
    parameter int FRAC_BITS      = 8,
    parameter int ANGLE_STEP_DEG = 15,
    parameter int ANGLE_W        = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [R_WIDTH-1:0] r,
    input  logic [ANGLE_W-1:0] angle_idx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [R_WIDTH:0]   x,
    output logic [R_WIDTH:0]   y,
    output logic               out_err
);

    localparam int CW   = FRAC_BITS + 1;
    localparam int AW   = R_WIDTH + FRAC_BITS + 1;
    localparam int CNTW = $clog2(FRAC_BITS + 1);

    localparam logic [AW-1:0]   HALF     = AW'(1) << (FRAC_BITS - 1);
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(FRAC_BITS);

    logic [1:0]         state_q, state_d;
    logic [R_WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]      sin_q, sin_d;
    logic [CW-1:0]      cos_q, cos_d;
    logic               sx_q, sx_d;
    logic               sy_q, sy_d;
    logic               errc_q, errc_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]      accx_q, accx_d;
    logic [AW-1:0]      accy_q, accy_d;
    logic [R_WIDTH:0]   x_q, x_d;
    logic [R_WIDTH:0]   y_q, y_d;
    logic               err_q, err_d;

    logic [CW-1:0]      lk_sin;
    logic [CW-1:0]      lk_cos;
    logic               lk_sx;
    logic               lk_sy;
    logic               lk_err;
    logic [AW-1:0]      nx;
    logic [AW-1:0]      ny;

    trig_coef_lookup #(
        .FRAC_BITS     (FRAC_BITS),
        .ANGLE_STEP_DEG(ANGLE_STEP_DEG),
        .ANGLE_W       (ANGLE_W)
    ) u_lookup (
        .angle_idx_i(angle_idx),
        .sin_mag_o  (lk_sin),
        .cos_mag_o  (lk_cos),
        .sign_x_o   (lk_sx),
        .sign_y_o   (lk_sy),
        .err_o      (lk_err)
    );

    // Round half up, then apply sign; magnitude never exceeds r
    function automatic logic [R_WIDTH:0] finish(
        input logic [AW-1:0] acc,
        input logic          neg
    );
        logic [R_WIDTH:0] m;
        m = (R_WIDTH + 1)'((acc + HALF) >> FRAC_BITS);
        return neg ? -m : m;
    endfunction

    assign nx = (accx_q << 1) + (cos_q[cnt_q] ? AW'(r_q) : '0);
    assign ny = (accy_q << 1) + (sin_q[cnt_q] ? AW'(r_q) : '0);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        sin_d   = sin_q;
        cos_d   = cos_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        errc_d  = errc_q;
        cnt_d   = cnt_q;
        accx_d  = accx_q;
        accy_d  = accy_q;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_MUL;
                    r_d     = r;
                    sin_d   = lk_sin;
                    cos_d   = lk_cos;
                    sx_d    = lk_sx;
                    sy_d    = lk_sy;
                    errc_d  = lk_err;
                    cnt_d   = CNT_INIT;
                    accx_d  = '0;
                    accy_d  = '0;
                end
            end
            ST_MUL: begin
                accx_d = nx;
                accy_d = ny;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    x_d     = finish(nx, sx_q);
                    y_d     = finish(ny, sy_q);
                    err_d   = errc_q;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            errc_q  <= 1'b0;
            cnt_q   <= '0;
            accx_q  <= '0;
            accy_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            errc_q  <= errc_d;
            cnt_q   <= cnt_d;
            accx_q  <= accx_d;
            accy_q  <= accy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign x         = x_q;
    assign y         = y_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_polar_to_cart_seq.sv
// Scoreboard bench for polar_to_cart_seq with directed vectors.
module tb_polar_to_cart_seq;

    localparam int RW   = 8;
    localparam int FB   = 8;
    localparam int STEP = 15;
    localparam int AWI  = 5;

    typedef struct packed {
        logic [RW:0] x;
        logic [RW:0] y;
        logic        err;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [RW-1:0] r = '0;
    logic [AWI-1:0] angle_idx = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_err;
    logic [RW:0]   x;
    logic [RW:0]   y;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_out = 0;
    int   n_exp = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    polar_to_cart_seq #(
        .R_WIDTH       (RW),
        .FRAC_BITS     (FB),
        .ANGLE_STEP_DEG(STEP),
        .ANGLE_W       (AWI)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .r        (r),
        .angle_idx(angle_idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x        (x),
        .y        (y),
        .out_err  (out_err)
    );

    function automatic exp_t mk(input logic [RW:0] ex, input logic [RW:0] ey, input logic ee);
        exp_t e;
        e.x   = ex;
        e.y   = ey;
        e.err = ee;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [RW-1:0] rv, input logic [AWI-1:0] iv,
                        input exp_t e, output int acc_cyc);
        int t;
        t = 0;
        acc_cyc = -1;
        while (!in_ready && t < 100) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (!in_ready) begin
            timeout("send_wait_in_ready");
        end else begin
            r         = rv;
            angle_idx = iv;
            in_valid  = 1'b1;
            @(posedge clock);
            #1;
            acc_cyc = cyc;
            exp_q.push_back(e);
            acc_q.push_back(cyc);
            n_exp++;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (exp_q.size() != 0) timeout("drain");
    endtask

    // Monitor: latency on each rising out_valid, data on each handshake
    initial begin
        logic prev_v;
        exp_t e;
        int   a;
        prev_v = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_v = 1'b0;
            end else begin
                if (in_ready && out_valid) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL ready_valid_overlap: both high at cycle %0d", cyc);
                end
                if (out_valid && !prev_v) begin
                    if (acc_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_valid: out_valid with no request at cycle %0d", cyc);
                    end else begin
                        a = acc_q.pop_front();
                        check("latency", cyc - a, FB + 1);
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: x=%0h y=%0h", x, y);
                    end else begin
                        e = exp_q.pop_front();
                        check("x", int'(x), int'(e.x));
                        check("y", int'(y), int'(e.y));
                        check("out_err", int'(out_err), int'(e.err));
                    end
                    n_out++;
                end
                prev_v = out_valid;
            end
        end
    end

    initial begin
        int a0;
        int a1;
        int t;
        #3;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_err", int'(out_err), 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        send(8'd100, 5'd1, mk(9'd96, 9'd26, 1'b0), a0);
        send(8'd100, 5'd3, mk(9'd71, 9'd71, 1'b0), a1);
        check("throughput", a1 - a0, FB + 3);
        send(8'd100, 5'd10, mk(9'h1A9, 9'd50, 1'b0), a0);
        send(8'd255, 5'd6, mk(9'd0, 9'd255, 1'b0), a0);
        send(8'd255, 5'd18, mk(9'd0, 9'h101, 1'b0), a0);
        send(8'd77, 5'd24, mk(9'd0, 9'd0, 1'b1), a0);
        send(8'd200, 5'd13, mk(9'h13F, 9'h1CC, 1'b0), a0);
        send(8'd100, 5'd23, mk(9'd96, 9'h1E6, 1'b0), a0);
        drain();

        // Backpressure: hold DONE, wiggle inputs, then release with in_valid high
        out_ready = 1'b0;
        send(8'd100, 5'd8, mk(9'h1CE, 9'd87, 1'b0), a0);
        t = 0;
        while (!out_valid && t < 40) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (!out_valid) timeout("bp_wait_valid");
        for (int i = 0; i < 5; i++) begin
            check("bp_x", int'(x), 9'h1CE);
            check("bp_y", int'(y), 87);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            r        = ~r;
            in_valid = ~in_valid;
            @(posedge clock);
            #1;
        end
        r         = 8'd5;
        angle_idx = 5'd0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("release_in_ready", int'(in_ready), 1);
        check("release_out_valid", int'(out_valid), 0);
        in_valid = 1'b0;
        drain();

        // Reset during the fourth multiply cycle discards the request
        send(8'd100, 5'd1, mk(9'd96, 9'd26, 1'b0), a0);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b0;
        n_exp  -= exp_q.size();
        exp_q.delete();
        acc_q.delete();
        #1;
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_x", int'(x), 0);
        check("mid_rst_y", int'(y), 0);
        check("mid_rst_err", int'(out_err), 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        send(8'd50, 5'd0, mk(9'd50, 9'd0, 1'b0), a0);
        drain();

        repeat (20) @(posedge clock);
        #1;
        check("output_count", n_out, n_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
